pipe_stage_fifo: RTL and testbench

PIPE_STAGE_FIFO -- requirements
Module: pipe_stage_fifo

---
 rtl/pipe_stage_fifo_pkg.sv | 28 ++
 rtl/pipe_stage_fifo_mem.sv | 39 +++
 rtl/pipe_stage_fifo.sv | 156 +++++++++++++++
 tb/tb_pipe_stage_fifo.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_fifo_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants and width helpers for the pipe_stage_fifo slice.
//   DEFAULT_WIDTH : default payload width in bits
//   DEFAULT_DEPTH : default entry count (power of two, >= 2)
//   count_width() : bits needed to hold an occupancy of 0..depth
//   ptr_width()   : bits needed to address depth entries
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;

    // Occupancy must represent the full state (== depth), hence depth + 1 codes.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointers address depth entries; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/pipe_stage_fifo_mem.sv
// -----------------------------------------------------------------------------
// pipe_stage_fifo_mem
// DEPTH x WIDTH register storage, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset: the reader
// only looks at an entry after it has been written.
// Ports:
//   clk     : clock, write on rising edge
//   wr_en   : write strobe
//   wr_addr : write entry index
//   wr_data : write payload
//   rd_addr : read entry index
//   rd_data : payload at rd_addr (combinational)
// -----------------------------------------------------------------------------
module pipe_stage_fifo_mem
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [ptr_width(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [ptr_width(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]            rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Store the incoming payload at the write index when strobed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/pipe_stage_fifo.sv
// -----------------------------------------------------------------------------
// pipe_stage_fifo
// Valid/ready pipeline stage buffering up to DEPTH payloads in FIFO order.
// Pointers wrap modulo DEPTH (DEPTH is a power of two). Flush and reset both
// empty the buffer on the next edge and discard any handshake in that cycle.
//
// Optional feature (compile-time macro PIPE_STAGE_FIFO_BYPASS_EN):
//   when the buffer is empty, the upstream payload is presented downstream in
//   the same cycle; if it is taken immediately it never touches storage.
//   Without the macro there is no combinational s_* to m_* path.
//
// Ports:
//   clk     : sole clock, rising edge
//   rst     : synchronous active-high reset
//   flush   : discard all held and in-flight entries
//   s_valid : upstream payload valid
//   s_ready : stage can accept (depends only on rst and count)
//   s_data  : upstream payload
//   m_valid : downstream payload valid
//   m_ready : downstream accepts
//   m_data  : downstream payload
//   count   : number of held entries
// -----------------------------------------------------------------------------
module pipe_stage_fifo
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WIDTH-1:0]              s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [WIDTH-1:0]              m_data,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = count_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic             empty_s;
    logic             s_ready_s;
    logic             m_valid_s;
    logic [WIDTH-1:0] m_data_s;
    logic [WIDTH-1:0] rd_data_s;
    logic             push_s;
    logic             pop_s;
    logic             bypass_take_s;
    logic             wr_en_s;
    logic             rd_adv_s;

    pipe_stage_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data (s_data),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data_s)
    );

    // Upstream readiness: reset and the registered count only, so m_ready
    // can never reach s_ready combinationally and a full stage refuses a push
    // even when a pop happens in the same cycle.
    always_comb begin
        empty_s   = (count_r == {CNT_W{1'b0}});
        s_ready_s = 1'b0;
        if (!rst && (count_r < FULL_C)) begin
            s_ready_s = 1'b1;
        end else begin
            s_ready_s = 1'b0;
        end
    end

    // Downstream presentation: head of storage, or the live input when bypassing
    always_comb begin
        m_valid_s = 1'b0;
        m_data_s  = rd_data_s;
`ifdef PIPE_STAGE_FIFO_BYPASS_EN
        if (empty_s) begin
            // Nothing buffered: forward the upstream beat unless it is being
            // discarded by flush or reset this cycle.
            m_valid_s = s_valid && !flush && !rst;
            m_data_s  = s_data;
        end else begin
            m_valid_s = 1'b1;
            m_data_s  = rd_data_s;
        end
`else
        if (empty_s) begin
            m_valid_s = 1'b0;
            m_data_s  = rd_data_s;
        end else begin
            m_valid_s = 1'b1;
            m_data_s  = rd_data_s;
        end
`endif
    end

    // Handshake decode: which transfers actually change stored state
    always_comb begin
        push_s        = s_valid && s_ready_s;
        pop_s         = m_valid_s && m_ready;
        bypass_take_s = 1'b0;
`ifdef PIPE_STAGE_FIFO_BYPASS_EN
        // Beat forwarded and consumed in the same cycle: storage untouched.
        if (empty_s && push_s && pop_s) begin
            bypass_take_s = 1'b1;
        end else begin
            bypass_take_s = 1'b0;
        end
`endif
        // Flush discards any handshake in its cycle; rst already gates push
        // through s_ready and the pointer/count update below.
        wr_en_s  = push_s && !flush && !bypass_take_s;
        rd_adv_s = pop_s && !flush && !rst && !bypass_take_s;
    end

    // Pointer and occupancy state; flush and reset share the same clearing path
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_adv_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_en_s, rd_adv_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign s_ready = s_ready_s;
    assign m_valid = m_valid_s;
    assign m_data  = m_data_s;
    assign count   = count_r;

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Scoreboard bench: two instances (DEPTH=4/WIDTH=16 and DEPTH=2/WIDTH=8).
// Expected payloads are queued at issue time; per-instance monitors pop and
// compare on every downstream handshake, sampled on the falling edge.
module tb_pipe_stage_fifo;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DEPTH=4 instance
    logic        a_flush, a_s_valid, a_s_ready, a_m_valid, a_m_ready;
    logic [15:0] a_s_data, a_m_data;
    logic [2:0]  a_count;

    // DEPTH=2 instance
    logic        b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready;
    logic [7:0]  b_s_data, b_m_data;
    logic [1:0]  b_count;

    pipe_stage_fifo #(.WIDTH(16), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .flush(a_flush),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
        .count(a_count)
    );

    pipe_stage_fifo #(.WIDTH(8), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .flush(b_flush),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .count(b_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int b_rcv    = 0;

    logic [15:0] a_exp [$];
    logic [7:0]  b_exp [$];
    logic [15:0] a_head;
    logic [7:0]  b_head;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the DEPTH=4 instance
    always @(negedge clk) begin
        if (!rst && !a_flush && a_m_valid && a_m_ready) begin
            n_checks++;
            if (a_exp.size() == 0) begin
                n_fail++;
                $display("FAIL a_order: got unexpected %h, required no output", a_m_data);
            end else begin
                a_head = a_exp.pop_front();
                if (a_m_data !== a_head) begin
                    n_fail++;
                    $display("FAIL a_order: got %h, required %h", a_m_data, a_head);
                end
            end
        end
    end

    // Monitor for the DEPTH=2 instance
    always @(negedge clk) begin
        if (!rst && !b_flush && b_m_valid && b_m_ready) begin
            n_checks++;
            b_rcv++;
            if (b_exp.size() == 0) begin
                n_fail++;
                $display("FAIL b_order: got unexpected %h, required no output", b_m_data);
            end else begin
                b_head = b_exp.pop_front();
                if (b_m_data !== b_head) begin
                    n_fail++;
                    $display("FAIL b_order: got %h, required %h", b_m_data, b_head);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    logic [15:0] fill_vals [4];
    int sent;

    initial begin
        fill_vals[0] = 16'h0011; fill_vals[1] = 16'h0022;
        fill_vals[2] = 16'h0033; fill_vals[3] = 16'h0044;
        rst = 1'b1;
        a_flush = 1'b0; a_s_valid = 1'b0; a_s_data = 16'h0000; a_m_ready = 1'b0;
        b_flush = 1'b0; b_s_valid = 1'b0; b_s_data = 8'h00;   b_m_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_s_ready_low", {31'd0, a_s_ready}, 32'd0);
        chk("rst_count", {29'd0, a_count}, 32'd0);
        chk("rst_m_valid", {31'd0, a_m_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_s_ready_after", {31'd0, a_s_ready}, 32'd1);
        chk("rst_b_count", {30'd0, b_count}, 32'd0);
        tick();

        // Fill with downstream stalled
        for (int i = 0; i < 4; i++) begin
            a_s_valid = 1'b1;
            a_s_data  = fill_vals[i];
            a_exp.push_back(fill_vals[i]);
            tick();
        end
        a_s_valid = 1'b0;
        chk("fill_count", {29'd0, a_count}, 32'd4);
        chk("fill_s_ready", {31'd0, a_s_ready}, 32'd0);
        chk("fill_head", {16'd0, a_m_data}, 32'h11);

        // Full with simultaneous offer and pop: 0x55 refused
        a_s_valid = 1'b1;
        a_s_data  = 16'h0055;
        a_m_ready = 1'b1;
        tick();
        a_s_valid = 1'b0;
        chk("full_pop_count", {29'd0, a_count}, 32'd3);

        // Drain remainder
        repeat (3) tick();
        a_m_ready = 1'b0;
        chk("drain_count", {29'd0, a_count}, 32'd0);
        chk("drain_m_valid", {31'd0, a_m_valid}, 32'd0);
        chk("drain_queue", a_exp.size(), 32'd0);

        // Output held stable while stalled
        a_s_valid = 1'b1;
        a_s_data  = 16'h0077;
        a_exp.push_back(16'h0077);
        tick();
        a_s_valid = 1'b0;
        chk("hold_valid_1", {31'd0, a_m_valid}, 32'd1);
        chk("hold_data_1", {16'd0, a_m_data}, 32'h77);
        tick();
        chk("hold_valid_2", {31'd0, a_m_valid}, 32'd1);
        chk("hold_data_2", {16'd0, a_m_data}, 32'h77);
        a_m_ready = 1'b1;
        tick();
        a_m_ready = 1'b0;
        chk("hold_count_after", {29'd0, a_count}, 32'd0);

        // Flush with three held and an offered 0xAA
        for (int i = 1; i <= 3; i++) begin
            a_s_valid = 1'b1;
            a_s_data  = 16'(i);
            tick();
        end
        chk("preflush_count", {29'd0, a_count}, 32'd3);
        a_flush   = 1'b1;
        a_s_valid = 1'b1;
        a_s_data  = 16'h00AA;
        #1;
        chk("flush_s_ready", {31'd0, a_s_ready}, 32'd1);
        tick();
        a_flush   = 1'b0;
        a_s_valid = 1'b0;
        chk("flush_count", {29'd0, a_count}, 32'd0);
        chk("flush_m_valid", {31'd0, a_m_valid}, 32'd0);
        a_s_valid = 1'b1;
        a_s_data  = 16'h005A;
        a_exp.push_back(16'h005A);
        tick();
        a_s_valid = 1'b0;
        a_m_ready = 1'b1;
        tick();
        a_m_ready = 1'b0;
        chk("postflush_count", {29'd0, a_count}, 32'd0);

        // Reset mid-stream
        for (int i = 0; i < 2; i++) begin
            a_s_valid = 1'b1;
            a_s_data  = 16'h0061 + 16'(i);
            tick();
        end
        a_s_valid = 1'b0;
        chk("prerst_count", {29'd0, a_count}, 32'd2);
        rst = 1'b1;
        #1;
        chk("midrst_s_ready", {31'd0, a_s_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("postrst_count", {29'd0, a_count}, 32'd0);
        chk("postrst_m_valid", {31'd0, a_m_valid}, 32'd0);
        chk("postrst_s_ready", {31'd0, a_s_ready}, 32'd1);
        tick();

        // Bypass / latency when empty
        a_s_valid = 1'b1;
        a_s_data  = 16'hBEEF;
        a_m_ready = 1'b1;
        a_exp.push_back(16'hBEEF);
        #1;
`ifdef PIPE_STAGE_FIFO_BYPASS_EN
        chk("byp_m_valid", {31'd0, a_m_valid}, 32'd1);
        chk("byp_m_data", {16'd0, a_m_data}, 32'hBEEF);
        tick();
        a_s_valid = 1'b0;
        chk("byp_count", {29'd0, a_count}, 32'd0);
        chk("byp_m_valid_after", {31'd0, a_m_valid}, 32'd0);
`else
        chk("lat_m_valid_same", {31'd0, a_m_valid}, 32'd0);
        tick();
        a_s_valid = 1'b0;
        chk("lat_m_valid_next", {31'd0, a_m_valid}, 32'd1);
        chk("lat_count_next", {29'd0, a_count}, 32'd1);
        tick();
        chk("lat_count_drained", {29'd0, a_count}, 32'd0);
`endif
        a_m_ready = 1'b0;
        chk("byp_queue", a_exp.size(), 32'd0);

        // Wrap-around on DEPTH=2 with toggling m_ready
        sent = 0;
        for (int c = 0; c < 80 && !(sent == 10 && b_rcv == 10); c++) begin
            b_m_ready = (c % 2 == 0);
            if (sent < 10) begin
                b_s_valid = 1'b1;
                b_s_data  = 8'(sent);
                if (b_s_ready) begin
                    b_exp.push_back(8'(sent));
                    sent++;
                end
            end else begin
                b_s_valid = 1'b0;
            end
            tick();
            chk("wrap_count_max", {31'd0, (b_count <= 2'd2)}, 32'd1);
        end
        b_s_valid = 1'b0;
        b_m_ready = 1'b0;
        chk("wrap_sent", sent, 32'd10);
        chk("wrap_received", b_rcv, 32'd10);
        chk("wrap_queue", b_exp.size(), 32'd0);
        chk("wrap_final_count", {30'd0, b_count}, 32'd0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
